regfile_access_scheduler: RTL

Sequences every access to the RV32I register file, which accepts either one write or one registered dual read per clock. Two requesters share the file through req/gnt/done handshakes: the core datapath and a debug/monitor port. The block drives the file's clk-domain control inputs (regWrite, rd, rs1, rs2, data), captures output1/output2, and returns read data to the winning requester.

---
 rtl/regfile_access_scheduler.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_access_scheduler.sv
// regfile_access_scheduler
//
// Serialises every access to an RV32I register file that accepts either one
// write or one registered dual read per clock. Two requesters (core datapath
// and debug/monitor port) share the file through req/gnt/done handshakes.
// A write takes ISSUE -> DONE, a read takes ISSUE -> CAPT -> DONE, and the
// scheduler always returns to IDLE for one cycle between accesses.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   core_req/we/rd/rs1/rs2/wdata  core request and its fields (held until gnt)
//   core_gnt, core_done       one-cycle pulses: accepted / complete
//   dbg_*                     debug requester, same meaning as core_*
//   rdata1, rdata2            read results, updated only at the end of CAPT
//   busy                      high whenever the scheduler is not in IDLE
//   rf_we, rf_rd, rf_rs1, rf_rs2, rf_wdata   register file control inputs
//   rf_out1, rf_out2          register file registered read outputs
//
// Build option
//   RR_ARB_EN  when defined, simultaneous requests alternate between the two
//              requesters (last_grant register); otherwise core always wins.
//
// Every output is driven straight from a flop.

module regfile_access_scheduler #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            core_req,
    input  logic            core_we,
    input  logic [AW-1:0]   core_rd,
    input  logic [AW-1:0]   core_rs1,
    input  logic [AW-1:0]   core_rs2,
    input  logic [XLEN-1:0] core_wdata,
    output logic            core_gnt,
    output logic            core_done,

    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [AW-1:0]   dbg_rd,
    input  logic [AW-1:0]   dbg_rs1,
    input  logic [AW-1:0]   dbg_rs2,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_gnt,
    output logic            dbg_done,

    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            busy,

    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [AW-1:0]   rf_rs1,
    output logic [AW-1:0]   rf_rs2,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [XLEN-1:0] rf_out1,
    input  logic [XLEN-1:0] rf_out2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            op_we_q, op_we_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [AW-1:0]   rf_rs1_q, rf_rs1_d;
    logic [AW-1:0]   rf_rs2_q, rf_rs2_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            core_gnt_q, core_gnt_d;
    logic            dbg_gnt_q, dbg_gnt_d;
    logic            core_done_q, core_done_d;
    logic            dbg_done_q, dbg_done_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] rdata1_q, rdata1_d;
    logic [XLEN-1:0] rdata2_q, rdata2_d;
`ifdef RR_ARB_EN
    logic            last_grant_q, last_grant_d;
`endif

    logic            req_any;
    logic            pick_dbg;
    logic            sel_we;
    logic [AW-1:0]   sel_rd;
    logic [AW-1:0]   sel_rs1;
    logic [AW-1:0]   sel_rs2;
    logic [XLEN-1:0] sel_wdata;

    assign req_any = core_req | dbg_req;

    // Winner selection; only consulted in IDLE. With round robin, a tie goes
    // to whoever did not win last time; a lone requester always wins.
    always_comb begin
        pick_dbg = dbg_req & ~core_req;
`ifdef RR_ARB_EN
        if (core_req && dbg_req) begin
            pick_dbg = (last_grant_q == OWN_CORE);
        end
`endif
    end

    assign sel_we    = pick_dbg ? dbg_we    : core_we;
    assign sel_rd    = pick_dbg ? dbg_rd    : core_rd;
    assign sel_rs1   = pick_dbg ? dbg_rs1   : core_rs1;
    assign sel_rs2   = pick_dbg ? dbg_rs2   : core_rs2;
    assign sel_wdata = pick_dbg ? dbg_wdata : core_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = ISSUE;
            ISSUE:   state_d = op_we_q ? DONE : CAPT;
            CAPT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of all registered outputs. Pulses (gnt, done, rf_we) are
    // computed one state early so that they are high during the state that
    // owns them.
    always_comb begin
        owner_d     = owner_q;
        op_we_d     = op_we_q;
        rf_rd_d     = rf_rd_q;
        rf_rs1_d    = rf_rs1_q;
        rf_rs2_d    = rf_rs2_q;
        rf_wdata_d  = rf_wdata_q;
        rdata1_d    = rdata1_q;
        rdata2_d    = rdata2_q;
        rf_we_d     = 1'b0;
        core_gnt_d  = 1'b0;
        dbg_gnt_d   = 1'b0;
        core_done_d = 1'b0;
        dbg_done_d  = 1'b0;
        busy_d      = (state_d != IDLE);
`ifdef RR_ARB_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    owner_d    = pick_dbg;
                    op_we_d    = sel_we;
                    rf_rd_d    = sel_rd;
                    rf_rs1_d   = sel_rs1;
                    rf_rs2_d   = sel_rs2;
                    rf_wdata_d = sel_wdata;
                    // x0 is immutable, so a write to it never reaches the file.
                    rf_we_d    = sel_we & (sel_rd != '0);
                    core_gnt_d = ~pick_dbg;
                    dbg_gnt_d  = pick_dbg;
`ifdef RR_ARB_EN
                    last_grant_d = pick_dbg;
`endif
                end
            end
            ISSUE: begin
                if (op_we_q) begin
                    core_done_d = (owner_q == OWN_CORE);
                    dbg_done_d  = (owner_q == OWN_DBG);
                end
            end
            CAPT: begin
                // The file may return anything for x0; reads of x0 are zero.
                rdata1_d    = (rf_rs1_q == '0) ? '0 : rf_out1;
                rdata2_d    = (rf_rs2_q == '0) ? '0 : rf_out2;
                core_done_d = (owner_q == OWN_CORE);
                dbg_done_d  = (owner_q == OWN_DBG);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_CORE;
            op_we_q     <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_rs1_q    <= '0;
            rf_rs2_q    <= '0;
            rf_wdata_q  <= '0;
            core_gnt_q  <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            core_done_q <= 1'b0;
            dbg_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
        end else begin
            owner_q     <= owner_d;
            op_we_q     <= op_we_d;
            rf_we_q     <= rf_we_d;
            rf_rd_q     <= rf_rd_d;
            rf_rs1_q    <= rf_rs1_d;
            rf_rs2_q    <= rf_rs2_d;
            rf_wdata_q  <= rf_wdata_d;
            core_gnt_q  <= core_gnt_d;
            dbg_gnt_q   <= dbg_gnt_d;
            core_done_q <= core_done_d;
            dbg_done_q  <= dbg_done_d;
            busy_q      <= busy_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
        end
    end

`ifdef RR_ARB_EN
    // Reset leaves the debug port as last winner so the core wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= OWN_DBG;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign core_gnt  = core_gnt_q;
    assign core_done = core_done_q;
    assign dbg_gnt   = dbg_gnt_q;
    assign dbg_done  = dbg_done_q;
    assign rdata1    = rdata1_q;
    assign rdata2    = rdata2_q;
    assign busy      = busy_q;
    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_rs1    = rf_rs1_q;
    assign rf_rs2    = rf_rs2_q;
    assign rf_wdata  = rf_wdata_q;

endmodule
